// File: rtl/ahblite_bus_matrix_1x4_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and data-phase owner indices
// for the 1x4 bus matrix.
package ahblite_bus_matrix_1x4_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_state_t;

  // One-hot data-phase owner: bits 0..3 are the slots, bit 4 is the default slave
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned SEL_DEF = 4;
  localparam logic [SEL_W-1:0] SEL_RESET = 5'b10000;

  function automatic logic slot_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahblite_bus_matrix_1x4_if.sv
// Master-port and slave-slot signals of the 1x4 AHB-Lite matrix, grouped as one bundle.
interface ahblite_bus_matrix_1x4_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
  logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
  logic        HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;

  // Matrix side
  modport slave (
    input  HADDR, HTRANS,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
    output HREADY, HRDATA, HRESP,
    output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
  );

  // Master and slave-slot environment side
  modport master (
    output HADDR, HTRANS,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
    input  HREADY, HRDATA, HRESP,
    input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
  );
endinterface

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped addresses: zero-wait OKAY for IDLE/BUSY,
// two-cycle ERROR response for NONSEQ/SEQ.
module ahblite_default_slave
  import ahblite_bus_matrix_1x4_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic dsel,
  input  logic trans_active,
  input  logic hready,
  output logic ready_out,
  output logic resp_out
);

  def_state_t state, state_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= DS_OKAY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b1;
    resp_out  = HRESP_OKAY;
    unique case (state)
      DS_OKAY: if (dsel && trans_active && hready) state_nxt = DS_ERR1;
      DS_ERR1: begin
        ready_out = 1'b0;
        resp_out  = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        resp_out  = HRESP_ERROR;
        // HREADY is high here, so a new unmapped transfer is already being accepted
        state_nxt = (dsel && trans_active) ? DS_ERR1 : DS_OKAY;
      end
      default: state_nxt = DS_OKAY;
    endcase
  end

endmodule

// File: rtl/ahblite_bus_matrix_1x4.sv
// Single-master AHB-Lite interconnect: address decode to four slots plus default
// slave, registered data-phase owner, and response mux back to the master.
module ahblite_bus_matrix_1x4
  import ahblite_bus_matrix_1x4_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_8000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_8000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h4001_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_0000
)(
  input logic                        HCLK,
  input logic                        HRESETn,
  ahblite_bus_matrix_1x4_if.slave    bus
);

  logic [3:0]       hit;
  logic [SEL_W-1:0] addr_sel;
  logic [SEL_W-1:0] dp_sel;
  logic             dsel;
  logic             def_ready, def_resp;

  assign hit[0] = slot_hit(bus.HADDR, S0_BASE, S0_MASK);
  assign hit[1] = slot_hit(bus.HADDR, S1_BASE, S1_MASK);
  assign hit[2] = slot_hit(bus.HADDR, S2_BASE, S2_MASK);
  assign hit[3] = slot_hit(bus.HADDR, S3_BASE, S3_MASK);

  // Priority to the lowest index keeps the selects one-hot on overlapping maps
  always_comb begin
    addr_sel = '0;
    if      (hit[0]) addr_sel[0]       = 1'b1;
    else if (hit[1]) addr_sel[1]       = 1'b1;
    else if (hit[2]) addr_sel[2]       = 1'b1;
    else if (hit[3]) addr_sel[3]       = 1'b1;
    else             addr_sel[SEL_DEF] = 1'b1;
  end

  assign dsel        = addr_sel[SEL_DEF];
  assign bus.HSEL_S0 = addr_sel[0];
  assign bus.HSEL_S1 = addr_sel[1];
  assign bus.HSEL_S2 = addr_sel[2];
  assign bus.HSEL_S3 = addr_sel[3];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        dp_sel <= SEL_RESET;
    else if (bus.HREADY) dp_sel <= addr_sel;
  end

  ahblite_default_slave u_def (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .dsel         (dsel),
    .trans_active (bus.HTRANS[1]),
    .hready       (bus.HREADY),
    .ready_out    (def_ready),
    .resp_out     (def_resp)
  );

  always_comb begin
    bus.HREADY = def_ready;
    bus.HRESP  = def_resp;
    bus.HRDATA = '0;
    if (dp_sel[0]) begin
      bus.HREADY = bus.HREADYOUT_S0;
      bus.HRESP  = bus.HRESP_S0;
      bus.HRDATA = bus.HRDATA_S0;
    end else if (dp_sel[1]) begin
      bus.HREADY = bus.HREADYOUT_S1;
      bus.HRESP  = bus.HRESP_S1;
      bus.HRDATA = bus.HRDATA_S1;
    end else if (dp_sel[2]) begin
      bus.HREADY = bus.HREADYOUT_S2;
      bus.HRESP  = bus.HRESP_S2;
      bus.HRDATA = bus.HRDATA_S2;
    end else if (dp_sel[3]) begin
      bus.HREADY = bus.HREADYOUT_S3;
      bus.HRESP  = bus.HRESP_S3;
      bus.HRDATA = bus.HRDATA_S3;
    end
  end

endmodule

// File: tb/tb_ahblite_bus_matrix_1x4.sv
// Directed bench for the 1x4 AHB-Lite matrix: decode, ownership, wait states,
// default-slave ERROR sequencing and asynchronous reset.
module tb_ahblite_bus_matrix_1x4;
  import ahblite_bus_matrix_1x4_pkg::*;

  logic HCLK;
  logic HRESETn;
  int unsigned vectors;
  int unsigned miscompares;

  ahblite_bus_matrix_1x4_if bus ();

  ahblite_bus_matrix_1x4 dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [3:0] hsel();
    return {bus.HSEL_S3, bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};
  endfunction

  task automatic check_rsp(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
    check({tag, "_hready"}, 32'(bus.HREADY), 32'(rdy));
    check({tag, "_hresp"},  32'(bus.HRESP),  32'(rsp));
    check({tag, "_hrdata"}, bus.HRDATA, rd);
  endtask

  task automatic check_st(input string tag, input def_state_t exp_st, input logic [4:0] exp_sel);
    check({tag, "_state"},  32'(dut.u_def.state), 32'(exp_st));
    check({tag, "_dp_sel"}, 32'(dut.dp_sel), 32'(exp_sel));
  endtask

  typedef struct { logic [31:0] addr; logic [3:0] sel; } dec_vec_t;
  dec_vec_t dec_tab[8];

  initial begin
    vectors = 0;
    miscompares = 0;
    dec_tab[0] = '{32'h0000_7FFC, 4'b0001};
    dec_tab[1] = '{32'h0000_8000, 4'b0000};
    dec_tab[2] = '{32'h2000_7FFF, 4'b0010};
    dec_tab[3] = '{32'h2000_8000, 4'b0000};
    dec_tab[4] = '{32'h4000_FFFF, 4'b0100};
    dec_tab[5] = '{32'h4001_FFFF, 4'b1000};
    dec_tab[6] = '{32'h4002_0000, 4'b0000};
    dec_tab[7] = '{32'h1000_0000, 4'b0000};

    HRESETn          = 1'b0;
    bus.HADDR        = 32'h0;
    bus.HTRANS       = HTRANS_IDLE;
    bus.HREADYOUT_S0 = 1'b1; bus.HRDATA_S0 = 32'hA5A5_1234; bus.HRESP_S0 = 1'b0;
    bus.HREADYOUT_S1 = 1'b1; bus.HRDATA_S1 = 32'h1111_1111; bus.HRESP_S1 = 1'b0;
    bus.HREADYOUT_S2 = 1'b1; bus.HRDATA_S2 = 32'h2222_2222; bus.HRESP_S2 = 1'b0;
    bus.HREADYOUT_S3 = 1'b1; bus.HRDATA_S3 = 32'h3333_3333; bus.HRESP_S3 = 1'b0;
    #12;
    check_rsp("rst", 1'b1, 1'b0, 32'h0);
    check_st("rst", DS_OKAY, 5'b10000);
    check("rst_hsel", 32'(hsel()), 32'h1);
    step();
    HRESETn = 1'b1;
    step();

    // Read slot 0
    bus.HADDR = 32'h0000_0010; bus.HTRANS = HTRANS_NONSEQ; #1;
    check("rd0_hsel", 32'(hsel()), 32'b0001);
    step();
    // Write slot 1 address phase during slot 0 data phase
    bus.HADDR = 32'h2000_0004; #1;
    check_rsp("rd0_dp", 1'b1, 1'b0, 32'hA5A5_1234);
    check("wr1_hsel", 32'(hsel()), 32'b0010);
    step();
    bus.HADDR = 32'h4000_0008; #1;
    check("rd2_hsel", 32'(hsel()), 32'b0100);
    check_st("wr1_dp", DS_OKAY, 5'b00010);
    check("wr1_hrdata", bus.HRDATA, 32'h1111_1111);
    step();

    // Slot 2 stalls three cycles while a slot 1 address waits
    bus.HADDR = 32'h2000_0000; bus.HREADYOUT_S2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rsp("wait_s2", 1'b0, 1'b0, 32'h2222_2222);
      check_st("wait_s2", DS_OKAY, 5'b00100);
      step();
    end
    bus.HREADYOUT_S2 = 1'b1; #1;
    check_rsp("rel_s2", 1'b1, 1'b0, 32'h2222_2222);
    check_st("rel_s2", DS_OKAY, 5'b00100);
    step();
    // Unmapped NONSEQ during slot 1 data phase
    bus.HADDR = 32'h6000_0000; #1;
    check_st("after_wait", DS_OKAY, 5'b00010);
    check("unm_hsel", 32'(hsel()), 32'b0000);
    step();
    bus.HTRANS = HTRANS_IDLE; #1;
    check_rsp("err1", 1'b0, 1'b1, 32'h0);
    check_st("err1", DS_ERR1, 5'b10000);
    step();
    #1;
    check_rsp("err2", 1'b1, 1'b1, 32'h0);
    check_st("err2", DS_ERR2, 5'b10000);
    step();
    #1;
    check_rsp("idle_unm", 1'b1, 1'b0, 32'h0);
    check_st("idle_unm", DS_OKAY, 5'b10000);

    // Combinational decode boundaries
    foreach (dec_tab[i]) begin
      bus.HADDR = dec_tab[i].addr; #1;
      check($sformatf("dec_%08h", dec_tab[i].addr), 32'(hsel()), 32'(dec_tab[i].sel));
    end
    step();

    // Two back-to-back unmapped NONSEQs
    bus.HADDR = 32'h6000_0000; bus.HTRANS = HTRANS_NONSEQ;
    step();
    bus.HADDR = 32'h6000_0004; #1;
    check_rsp("b2b_err1a", 1'b0, 1'b1, 32'h0);
    check_st("b2b_err1a", DS_ERR1, 5'b10000);
    step(); #1;
    check_rsp("b2b_err2a", 1'b1, 1'b1, 32'h0);
    step();
    bus.HTRANS = HTRANS_IDLE; #1;
    check_rsp("b2b_err1b", 1'b0, 1'b1, 32'h0);
    check_st("b2b_err1b", DS_ERR1, 5'b10000);
    step(); #1;
    check_rsp("b2b_err2b", 1'b1, 1'b1, 32'h0);
    step(); #1;
    check_rsp("b2b_okay", 1'b1, 1'b0, 32'h0);
    check_st("b2b_okay", DS_OKAY, 5'b10000);

    // Slot 3 response path, including HRESP and a wait state
    bus.HADDR = 32'h4001_0010; bus.HTRANS = HTRANS_NONSEQ;
    bus.HREADYOUT_S3 = 1'b0; bus.HRESP_S3 = 1'b1;
    step();
    bus.HADDR = 32'h0; bus.HTRANS = HTRANS_IDLE; #1;
    check_rsp("s3_dp", 1'b0, 1'b1, 32'h3333_3333);
    check_st("s3_dp", DS_OKAY, 5'b01000);
    bus.HREADYOUT_S3 = 1'b1; bus.HRESP_S3 = 1'b0;
    step();

    // Reset asserted during ERR1
    bus.HADDR = 32'h6000_0000; bus.HTRANS = HTRANS_NONSEQ;
    step();
    bus.HTRANS = HTRANS_IDLE; #1;
    check_st("pre_rst", DS_ERR1, 5'b10000);
    HRESETn = 1'b0; #1;
    check_rsp("mid_rst", 1'b1, 1'b0, 32'h0);
    check_st("mid_rst", DS_OKAY, 5'b10000);
    step();
    HRESETn = 1'b1;
    step(); #1;
    check_rsp("post_rst", 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
